// File: rtl/codec_share_arbiter_pkg.sv
// Shared definitions for the codec-sharing arbiter: default width, output-stage
// state encoding and requester ids.
package codec_share_arbiter_pkg;

  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/codec_share_arbiter_byte_codec.sv
// Combinational byte codec: bit-reverse then invert. Applying it twice returns
// the original value, so one instance serves both encode and decode.
module byte_codec #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  // Mirror the bit order and complement each bit.
  always_comb begin
    out_data = {DATA_W{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      out_data[i] = ~in_data[DATA_W-1-i];
    end
  end

endmodule

// File: rtl/codec_share_arbiter.sv
// Round-robin arbiter sharing one byte codec between two requesters, with a
// single registered output stage tagged by source and saturating grant counters.
module codec_share_arbiter
  import codec_share_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_src,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_src_q, out_src_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  logic              can_load_s;
  logic              grant0_s;
  logic              grant1_s;
  logic [DATA_W-1:0] sel_data_s;
  logic [DATA_W-1:0] coded_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Arbitration: readies are held low during reset so no handshake completes.
  always_comb begin
    can_load_s = 1'b0;
    grant0_s   = 1'b0;
    grant1_s   = 1'b0;
    if (rst) begin
      can_load_s = 1'b0;
    end else if (state_q == ST_EMPTY) begin
      can_load_s = 1'b1;
    end else begin
      can_load_s = out_ready;
    end
    if (!can_load_s) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (last_grant_q == REQ1) begin
        grant0_s = 1'b1;
      end else begin
        grant1_s = 1'b1;
      end
    end else begin
      grant0_s = req0_valid;
      grant1_s = req1_valid;
    end
    sel_data_s = grant1_s ? req1_data : req0_data;
  end

  byte_codec #(
    .DATA_W(DATA_W)
  ) u_codec (
    .in_data (sel_data_s),
    .out_data(coded_s)
  );

  // Output stage FSM, source tag, round-robin pointer and counters.
  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    if (grant0_s || grant1_s) begin
      state_d      = ST_FULL;
      out_data_d   = coded_s;
      out_src_d    = grant1_s ? REQ1 : REQ0;
      last_grant_d = grant1_s ? REQ1 : REQ0;
      if (grant1_s) begin
        cnt1_d = sat_inc(cnt1_q);
      end else begin
        cnt0_d = sat_inc(cnt0_q);
      end
    end else begin
      case (state_q)
        ST_EMPTY: state_d = ST_EMPTY;
        ST_FULL:  state_d = out_ready ? ST_EMPTY : ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      out_data_q   <= {DATA_W{1'b0}};
      out_src_q    <= REQ0;
      last_grant_q <= REQ1;
      cnt0_q       <= {CNT_W{1'b0}};
      cnt1_q       <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign out_valid  = (state_q == ST_FULL);
  assign busy       = (state_q == ST_FULL);
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

endmodule

// File: tb/tb_codec_share_arbiter.sv
// Scoreboard bench for codec_share_arbiter: directed scenarios followed by
// random traffic, checked against a transaction-level reference model.
module tb_codec_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, out_ready;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, out_valid, out_src, busy;
  logic [7:0] out_data;
  logic [15:0] grant_cnt0, grant_cnt1;

  logic       s_req0_ready, s_req1_ready, s_out_valid, s_out_src, s_busy;
  logic [7:0] s_out_data;
  logic [1:0] s_cnt0, s_cnt1;

  always #5 clk = ~clk;

  codec_share_arbiter #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1),
    .busy(busy)
  );

  // Narrow-counter instance on the same stimulus, used for saturation checks.
  codec_share_arbiter #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_src(s_out_src),
    .out_ready(out_ready), .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1),
    .busy(s_busy)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       src;
  } item_t;

  item_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  // Reference model state: transaction level, unbounded counts.
  bit    m_full;
  bit    m_last;
  int    m_cnt0, m_cnt1;

  function automatic logic [7:0] xf(input logic [7:0] x);
    logic [7:0] r;
    r = {<<{x}};
    return ~r;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_last = 1'b1;
    m_cnt0 = 0;
    m_cnt1 = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model.
  task automatic cycle(input logic v0, input logic [7:0] d0, input logic v1,
                       input logic [7:0] d1, input logic ordy, input logic r);
    bit g0, g1, can;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; out_ready = ordy;
    #1;
    if (r) begin
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      model_reset();
    end else begin
      can = !m_full || ordy;
      g0 = 1'b0; g1 = 1'b0;
      if (can && v0 && v1) begin
        if (m_last) g0 = 1'b1; else g1 = 1'b1;
      end else if (can) begin
        g0 = v0; g1 = v1;
      end
      check("ready0", 32'(req0_ready), 32'(g0));
      check("ready1", 32'(req1_ready), 32'(g1));
      check("out_valid", 32'(out_valid), 32'(m_full));
      check("busy", 32'(busy), 32'(m_full));
      check("cnt0", 32'(grant_cnt0), 32'(sat(m_cnt0, 65535)));
      check("cnt1", 32'(grant_cnt1), 32'(sat(m_cnt1, 65535)));
      check("sat_cnt0", 32'(s_cnt0), 32'(sat(m_cnt0, 3)));
      check("sat_cnt1", 32'(s_cnt1), 32'(sat(m_cnt1, 3)));
      if (m_full && exp_q.size() > 0) begin
        check("held_data", 32'(out_data), 32'(exp_q[0].data));
        check("held_src", 32'(out_src), 32'(exp_q[0].src));
      end
      if (g0 || g1) begin
        exp_q.push_back('{data: xf(g1 ? d1 : d0), src: g1});
        m_last = g1;
        m_full = 1'b1;
        if (g1) m_cnt1++; else m_cnt0++;
      end else if (m_full && ordy) begin
        m_full = 1'b0;
      end
    end
  endtask

  // Monitor: consume one expected item per completed output handshake.
  always @(negedge clk) begin
    item_t it;
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL out_unexpected: got data %0h src %0d expected no output", out_data, out_src);
      end else begin
        it = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(it.data));
        check("out_src", 32'(out_src), 32'(it.src));
      end
    end
  end

  initial begin
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; out_ready = 1'b0;
    model_reset();

    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("reset_out_data", 32'(out_data), 32'h00);
    check("reset_out_src", 32'(out_src), 32'd0);

    // Single request from requester 0.
    cycle(1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_data", 32'(out_data), 32'h7F);
    check("t1_cnt0", 32'(grant_cnt0), 32'd1);

    // Both valid every cycle: alternation.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'h0F, 1'b1, 8'hF0, 1'b1, 1'b0);

    // Stall for 5 cycles, then release.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'h33, 1'b1, 8'hCC, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h33, 1'b1, 8'hCC, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    // Involution through requester 1.
    cycle(1'b0, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check("involution", 32'(out_data), 32'hA5);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    // Saturation of the narrow counter: several grants to requester 0.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i), 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    check("sat_hold", 32'(s_cnt0), 32'd3);

    // Reset while FULL and stalled, then contested grant goes to requester 0.
    cycle(1'b0, 8'h00, 1'b1, 8'h11, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b1, 8'h44, 1'b0, 1'b1);
    cycle(1'b1, 8'h22, 1'b1, 8'h44, 1'b1, 1'b0);
    check("post_rst_src", 32'(req0_ready), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 199) == 0);
    end
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
